// File: rtl/dbuf_rd_ctrl.sv
// Read-side controller of the packet double buffer. Drains the two banks of
// the buffer RAM in strict alternation, turns the RAM's one-cycle read latency
// into a valid/ready beat stream with a last flag, and hands each bank back to
// the writer once its final beat has been accepted.
module dbuf_rd_ctrl #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_i,
  input  logic              commit_bank_i,
  input  logic [ADDR_W-1:0] commit_len_i,
  output logic              release_o,
  output logic              release_bank_o,
  output logic              rden_b_o,
  output logic [ADDR_W-1:0] rdaddr_b_o,
  input  logic [DATA_W-1:0] rddata_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              err_o
);

  localparam int                IDX_W   = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] LEN_ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] MAX_LEN = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [1:0]        pending_q, pending_d;
  logic [ADDR_W-1:0] len_q [2];
  logic              err_q;
  logic              commit_bad, commit_ok;
  logic              exp_bank_q, bank_q;
  logic [ADDR_W-1:0] blen_q, beat_cnt_q;
  logic              release_q, release_bank_q;
  logic              start, issue, last_issue, done;
  logic              rd_vld_q, rd_last_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              fifo_wptr_q, fifo_rptr_q;
  logic [1:0]        fifo_cnt_q;
  logic              fifo_head_vld, fifo_pop, push, pop, credit;
  logic [2:0]        occ;

  // Commit acceptance: a finishing drain frees its bank before a same-cycle
  // commit of that bank is judged, so the commit re-arms it cleanly.
  always_comb begin
    // NOTE: blocking '=' here so each statement sees the updates above it;
    // only clocked blocks use '<='.
    pending_d = pending_q;
    if (done) pending_d[bank_q] = 1'b0;
    commit_bad = commit_i & (pending_d[commit_bank_i] | (commit_len_i == '0) |
                             (commit_len_i > MAX_LEN));
    commit_ok  = commit_i & ~commit_bad;
    if (commit_ok) pending_d[commit_bank_i] = 1'b1;
  end

  // Pending flags, per-bank lengths and the sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (commit_ok)  len_q[commit_bank_i] <= commit_len_i;
      if (commit_bad) err_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: one idle cycle per bank gives the writer's registered
  // write path time to land before the first read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)      state_d = READ;
      READ:    if (last_issue) state_d = DRAIN;
      DRAIN:   if (done)       state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM outputs: bank start, read issue under credit, drain completion.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    start      = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE:  start = pending_q[exp_bank_q];
      READ: begin
        issue      = credit;
        last_issue = credit & (beat_cnt_q == blen_q - LEN_ONE);
      end
      DRAIN: done = pop & m_last_o;
      default: ;
    endcase
  end

  // Active bank, beat counter, bank alternation and the release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_bank_q     <= 1'b0;
      bank_q         <= 1'b0;
      blen_q         <= '0;
      beat_cnt_q     <= '0;
      release_q      <= 1'b0;
      release_bank_q <= 1'b0;
    end else begin
      if (start) begin
        bank_q     <= exp_bank_q;
        blen_q     <= len_q[exp_bank_q];
        beat_cnt_q <= '0;
      end else if (issue) begin
        beat_cnt_q <= beat_cnt_q + LEN_ONE;
      end
      if (done) begin
        exp_bank_q     <= ~exp_bank_q;
        release_bank_q <= bank_q;
      end
      release_q <= done;
    end
  end

  // Read-return tracking: rddata_i is valid the cycle after a read issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= last_issue;
    end
  end

  // The returning RAM word is offered directly when the FIFO is empty; it is
  // stored only if not taken in that same cycle. Credit counts it either way.
  assign fifo_head_vld = (fifo_cnt_q != 2'd0);
  assign pop           = m_valid_o & m_ready_i;
  assign fifo_pop      = pop & fifo_head_vld;
  assign push          = rd_vld_q & (fifo_head_vld | ~pop);
  assign occ           = {1'b0, fifo_cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
  assign credit        = (occ < 3'd2);

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= '0;
    end else begin
      if (push)     fifo_wptr_q <= ~fifo_wptr_q;
      if (fifo_pop) fifo_rptr_q <= ~fifo_rptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the occupancy count alone decides validity.
    if (push) begin
      fifo_data_q[fifo_wptr_q] <= rddata_i;
      fifo_last_q[fifo_wptr_q] <= rd_last_q;
    end
  end

  assign m_valid_o      = fifo_head_vld | rd_vld_q;
  assign m_data_o       = fifo_head_vld ? fifo_data_q[fifo_rptr_q] :
                          (rd_vld_q ? rddata_i : '0);
  assign m_last_o       = fifo_head_vld ? fifo_last_q[fifo_rptr_q] :
                          (rd_vld_q & rd_last_q);
  assign rden_b_o       = issue;
  assign rdaddr_b_o     = {bank_q, beat_cnt_q[IDX_W-1:0]};
  assign release_o      = release_q;
  assign release_bank_o = release_bank_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_dbuf_rd_ctrl.sv
// Bench for dbuf_rd_ctrl: a RAM model answers reads with an address-derived
// pattern, stimulus queues the expected reads, beats and releases, and a
// negedge monitor consumes those queues as the DUT produces events.
module tb_dbuf_rd_ctrl;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 10;
  localparam int IDX_W  = ADDR_W - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              commit_i = 1'b0;
  logic              commit_bank_i = 1'b0;
  logic [ADDR_W-1:0] commit_len_i = '0;
  logic              release_o, release_bank_o, rden_b_o;
  logic [ADDR_W-1:0] rdaddr_b_o;
  logic [DATA_W-1:0] rddata_i;
  logic              m_valid_o;
  logic              m_ready_i = 1'b0;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o, err_o;

  dbuf_rd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_i(commit_i), .commit_bank_i(commit_bank_i), .commit_len_i(commit_len_i),
    .release_o(release_o), .release_bank_o(release_bank_o),
    .rden_b_o(rden_b_o), .rdaddr_b_o(rdaddr_b_o), .rddata_i(rddata_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  int                vectors = 0;
  int                miscompares = 0;
  int                cyc = 0;
  logic [31:0]       salt = 32'h1234_5678;
  beat_t             exp_beats[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic              exp_rel[$];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                            input logic [31:0] s);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++)
      d[i*32 +: 32] = s ^ (32'(i) << 24) ^ (32'(a) * 32'h0001_0001);
    return d;
  endfunction

  // RAM read port: registered data one cycle after rden, garbage otherwise.
  always @(posedge clk) begin
    if (rden_b_o) rddata_i <= pat(rdaddr_b_o, salt);
    else          rddata_i <= {16{$urandom}};
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state.
  int                reads = 0;
  int                hs = 0;
  int                occ = 0;
  int                last_hs_cyc = -10;
  logic              stall_q = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic              stall_last;
  logic              pop_now;
  beat_t             got;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ     = 0;
      stall_q = 1'b0;
    end else begin
      pop_now = m_valid_o & m_ready_i;
      if (stall_q) begin
        check("hold_valid", m_valid_o, 1'b1);
        check("hold_data", m_data_o, stall_data);
        check("hold_last", m_last_o, stall_last);
      end
      if (rden_b_o) begin
        reads++;
        if (exp_addr.size() == 0) check("spurious_read", exp_addr.size(), 1);
        else                      check("rd_addr", rdaddr_b_o, exp_addr.pop_front());
      end
      occ = occ + int'(rden_b_o) - int'(pop_now);
      if (rden_b_o) check("occupancy_le_2", occ <= 2, 1'b1);
      if (pop_now) begin
        hs++;
        if (exp_beats.size() == 0) begin
          check("spurious_beat", exp_beats.size(), 1);
        end else begin
          got = exp_beats.pop_front();
          check("beat_data", m_data_o, got.data);
          check("beat_last", m_last_o, got.last);
        end
        if (m_last_o) last_hs_cyc = cyc;
      end
      if (release_o) begin
        if (exp_rel.size() == 0) check("spurious_release", exp_rel.size(), 1);
        else                     check("release_bank", release_bank_o, exp_rel.pop_front());
        check("release_timing", cyc, last_hs_cyc + 1);
      end
      stall_q    = m_valid_o & ~m_ready_i;
      stall_data = m_data_o;
      stall_last = m_last_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic bank, input logic [ADDR_W-1:0] len);
    commit_i      = 1'b1;
    commit_bank_i = bank;
    commit_len_i  = len;
    tick(1);
    commit_i      = 1'b0;
  endtask

  task automatic expect_bank(input logic bank, input int len);
    logic [ADDR_W-1:0] a;
    beat_t             b;
    for (int i = 0; i < len; i++) begin
      a      = {bank, IDX_W'(i)};
      b.data = pat(a, salt);
      b.last = (i == len - 1);
      exp_addr.push_back(a);
      exp_beats.push_back(b);
    end
    exp_rel.push_back(bank);
  endtask

  task automatic wait_drain(input int budget, input bit toggle);
    int n = 0;
    while ((exp_beats.size() + exp_addr.size() + exp_rel.size()) != 0 && n < budget) begin
      if (toggle) m_ready_i = ~m_ready_i;
      tick(1);
      n++;
    end
    check("drain_within_budget", n < budget, 1'b1);
    tick(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {release_o, release_bank_o, rden_b_o, rdaddr_b_o, m_valid_o,
                m_last_o, err_o}, '0);
    check({tag, "_data"}, m_data_o, '0);
  endtask

  initial begin
    int k, rden_at, vld_at, r0, base, n;

    // Reset state.
    #12;
    check_outputs_zero("reset_outputs");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Bank1 committed before bank0: bank0 still drains first.
    m_ready_i = 1'b1;
    expect_bank(1'b0, 2);
    expect_bank(1'b1, 3);
    commit(1'b1, 10'd3);
    commit(1'b0, 10'd2);
    wait_drain(100, 1'b0);

    // Bank0, 4 beats, ready high: latency and sustained throughput.
    salt = 32'hA5A5_0001;
    expect_bank(1'b0, 4);
    k = cyc;
    rden_at = -1;
    vld_at  = -1;
    commit(1'b0, 10'd4);
    repeat (8) begin
      @(negedge clk);
      if (rden_b_o && rden_at < 0) rden_at = cyc;
      if (m_valid_o && vld_at < 0) vld_at = cyc;
    end
    tick(1);
    check("latency_first_rden", rden_at, k + 2);
    check("latency_first_valid", vld_at, k + 3);
    wait_drain(100, 1'b0);

    // Single-beat bank1 held off by m_ready_i low for 5 cycles.
    salt = 32'h0F0F_0002;
    m_ready_i = 1'b0;
    expect_bank(1'b1, 1);
    r0 = reads;
    commit(1'b1, 10'd1);
    n = 0;
    while (!m_valid_o && n < 20) begin
      tick(1);
      n++;
    end
    check("single_valid_seen", m_valid_o, 1'b1);
    tick(5);
    check("single_read_count", reads - r0, 1);
    m_ready_i = 1'b1;
    wait_drain(50, 1'b0);

    // Full 512-beat bank0 with m_ready_i toggling every cycle.
    salt = 32'h3C3C_0003;
    expect_bank(1'b0, 512);
    commit(1'b0, 10'd512);
    wait_drain(2500, 1'b1);
    m_ready_i = 1'b1;

    // Protocol errors: double commit of bank0, zero length on bank1.
    salt = 32'h7E7E_0004;
    expect_bank(1'b1, 1);
    expect_bank(1'b0, 2);
    commit(1'b0, 10'd2);
    check("err_clean", err_o, 1'b0);
    commit(1'b0, 10'd5);
    check("err_double_commit", err_o, 1'b1);
    commit(1'b1, 10'd0);
    check("err_len_zero", err_o, 1'b1);
    commit(1'b1, 10'd1);
    wait_drain(100, 1'b0);
    check("err_sticky", err_o, 1'b1);

    // Reset during beat 3 of 8, then a fresh bank0 transfer.
    salt = 32'hC3C3_0005;
    expect_bank(1'b1, 8);
    commit(1'b1, 10'd8);
    base = hs;
    n = 0;
    while (hs - base < 3 && n < 50) begin
      tick(1);
      n++;
    end
    check("reached_beat_3", hs - base, 3);
    #2 rst_n = 1'b0;
    exp_beats.delete();
    exp_addr.delete();
    exp_rel.delete();
    #1 check_outputs_zero("midbank_reset_outputs");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_outputs_zero("post_reset_idle");
    salt = 32'h5A5A_0006;
    expect_bank(1'b0, 3);
    commit(1'b0, 10'd3);
    wait_drain(100, 1'b0);

    check("queues_empty", exp_beats.size() + exp_addr.size() + exp_rel.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
